mcp23s17_responder: RTL and testbench

MCP23S17_RESPONDER -- requirements
Module: mcp23s17_responder

---
 rtl/mcp23s17_pkg.sv | 46 ++++
 rtl/mcp23s17_responder_if.sv | 11 +
 rtl/mcp23s17_responder_spi_slave_core.sv | 92 +++++++++
 rtl/mcp23s17_responder.sv | 178 +++++++++++++++++
 tb/tb_mcp23s17_responder.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/mcp23s17_pkg.sv
// Shared constants, register map and FSM state type for the MCP23S17 SPI responder.
// BANK=0 addressing only: bit 0 of a register address selects port B.
package mcp23s17_pkg;

  localparam logic [3:0] OPCODE_PREFIX = 4'b0100;

  localparam logic [7:0] ADDR_IODIR   = 8'h00;
  localparam logic [7:0] ADDR_GPINTEN = 8'h04;
  localparam logic [7:0] ADDR_IOCON   = 8'h0A;
  localparam logic [7:0] ADDR_GPPU    = 8'h0C;
  localparam logic [7:0] ADDR_INTF    = 8'h0E;
  localparam logic [7:0] ADDR_INTCAP  = 8'h10;
  localparam logic [7:0] ADDR_GPIO    = 8'h12;
  localparam logic [7:0] ADDR_OLAT    = 8'h14;
  localparam logic [7:0] ADDR_LAST    = 8'h15;

  localparam int IOCON_MIRROR = 6;
  localparam int IOCON_SEQOP  = 5;
  localparam int IOCON_HAEN   = 3;
  localparam int IOCON_INTPOL = 1;

  localparam logic [15:0] IODIR_RST = 16'hFFFF;
  localparam logic [15:0] REG16_RST = 16'h0000;
  localparam logic [7:0]  IOCON_RST = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPCODE,
    ST_ADDR,
    ST_DATA,
    ST_IGNORE
  } state_t;

  // Port-A address of an A/B register pair.
  function automatic logic [7:0] reg_base(input logic [7:0] addr);
    return addr & 8'hFE;
  endfunction

  // Replace one port byte of a 16-bit B:A register.
  function automatic logic [15:0] merge_byte(input logic [15:0] old_val,
                                             input logic        port_b,
                                             input logic [7:0]  new_byte);
    return port_b ? {new_byte, old_val[7:0]} : {old_val[15:8], new_byte};
  endfunction

endpackage

// File: rtl/mcp23s17_responder_if.sv
// SPI bus between host (master) and the MCP23S17 responder (slave).
interface mcp23s17_responder_if;
  logic sck;
  logic cs;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output sck, output cs, output mosi, input miso, input miso_oe);
  modport slave  (input sck, input cs, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/mcp23s17_responder_spi_slave_core.sv
// SPI mode-0 slave datapath: input synchronisers, sck edge detection,
// byte shift-in with byte_done strobe, and byte shift-out on sck falling edges.
module spi_slave_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sck,
  input  logic        cs,
  input  logic        mosi,
  input  logic [15:0] gpio_in,
  input  logic [7:0]  tx_byte,
  output logic        cs_s,
  output logic        cs_fall,
  output logic        byte_done,
  output logic [7:0]  rx_byte,
  output logic [15:0] pins_s,
  output logic        miso_bit
);

  logic [1:0]  sck_sync_q, sck_sync_d;
  logic [1:0]  cs_sync_q, cs_sync_d;
  logic [1:0]  mosi_sync_q, mosi_sync_d;
  logic [15:0] gpio_s1_q, gpio_s1_d;
  logic [15:0] gpio_s2_q, gpio_s2_d;
  logic        sck_prev_q, sck_prev_d;
  logic        cs_prev_q, cs_prev_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  rx_q, rx_d;
  logic [7:0]  tx_q, tx_d;
  logic        sck_s, mosi_s, sck_rise, sck_fall;

  assign sck_s     = sck_sync_q[1];
  assign cs_s      = cs_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign sck_rise  = sck_s & ~sck_prev_q;
  assign sck_fall  = ~sck_s & sck_prev_q;
  assign cs_fall   = cs_prev_q & ~cs_s;
  assign byte_done = sck_rise & ~cs_s & (bit_cnt_q == 3'd7);
  assign rx_byte   = {rx_q, mosi_s};
  assign pins_s    = gpio_s2_q;
  assign miso_bit  = tx_q[7];

  always_comb begin
    sck_sync_d  = {sck_sync_q[0], sck};
    cs_sync_d   = {cs_sync_q[0], cs};
    mosi_sync_d = {mosi_sync_q[0], mosi};
    gpio_s1_d   = gpio_in;
    gpio_s2_d   = gpio_s1_q;
    sck_prev_d  = sck_s;
    cs_prev_d   = cs_s;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    // A deselected bus discards any partially received byte.
    if (cs_s) begin
      bit_cnt_d = 3'd0;
    end else if (sck_rise) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      rx_d      = {rx_q[5:0], mosi_s};
    end
    // First falling edge after a byte boundary loads a fresh byte, the rest shift.
    if (sck_fall && !cs_s) begin
      tx_d = (bit_cnt_q == 3'd0) ? tx_byte : {tx_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= 2'b00;
      cs_sync_q   <= 2'b00;
      mosi_sync_q <= 2'b00;
      gpio_s1_q   <= 16'h0000;
      gpio_s2_q   <= 16'h0000;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b0;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 7'd0;
      tx_q        <= 8'd0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      gpio_s1_q   <= gpio_s1_d;
      gpio_s2_q   <= gpio_s2_d;
      sck_prev_q  <= sck_prev_d;
      cs_prev_q   <= cs_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
    end
  end

endmodule

// File: rtl/mcp23s17_responder.sv
// MCP23S17-compatible SPI GPIO expander: transaction FSM, BANK=0 register file,
// auto-incrementing register pointer and interrupt-on-change logic.
module mcp23s17_responder
  import mcp23s17_pkg::*;
#(
  parameter logic [2:0] HW_ADDR = 3'b000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  mcp23s17_responder_if.slave        spi,
  input  logic [15:0]                gpio_in,
  output logic [15:0]                gpio_out,
  output logic [15:0]                iodir,
  output logic                       inta
);

  state_t      state_q, state_d;
  logic        rw_q, rw_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [15:0] iodir_q, iodir_d;
  logic [15:0] gpinten_q, gpinten_d;
  logic [7:0]  iocon_q, iocon_d;
  logic [15:0] gppu_q, gppu_d;
  logic [15:0] intf_q, intf_d;
  logic [15:0] intcap_q, intcap_d;
  logic [15:0] olat_q, olat_d;
  logic [15:0] pins_prev_q, pins_prev_d;

  logic        cs_s, cs_fall, byte_done, miso_bit;
  logic [7:0]  rx_byte, rd_data;
  logic [15:0] pins_s, rd16, gpio_val;
  logic [7:0]  ptr_base;
  logic        port_b, wr_en, rd_done, int_active;
  logic [1:0]  rd_clr;
  logic [7:0]  chg [2];

  spi_slave_core u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .sck       (spi.sck),
    .cs        (spi.cs),
    .mosi      (spi.mosi),
    .gpio_in   (gpio_in),
    .tx_byte   (rd_data),
    .cs_s      (cs_s),
    .cs_fall   (cs_fall),
    .byte_done (byte_done),
    .rx_byte   (rx_byte),
    .pins_s    (pins_s),
    .miso_bit  (miso_bit)
  );

  assign ptr_base = reg_base(ptr_q);
  assign port_b   = ptr_q[0];
  assign gpio_val = (iodir_q & pins_s) | (~iodir_q & olat_q);

  always_comb begin
    rd16 = 16'h0000;
    case (ptr_base)
      ADDR_IODIR:   rd16 = iodir_q;
      ADDR_GPINTEN: rd16 = gpinten_q;
      ADDR_IOCON:   rd16 = {iocon_q, iocon_q};
      ADDR_GPPU:    rd16 = gppu_q;
      ADDR_INTF:    rd16 = intf_q;
      ADDR_INTCAP:  rd16 = intcap_q;
      ADDR_GPIO:    rd16 = gpio_val;
      ADDR_OLAT:    rd16 = olat_q;
      default:      rd16 = 16'h0000;
    endcase
    rd_data = port_b ? rd16[15:8] : rd16[7:0];
  end

  always_comb begin
    state_d   = state_q;
    rw_d      = rw_q;
    ptr_d     = ptr_q;
    iodir_d   = iodir_q;
    gpinten_d = gpinten_q;
    iocon_d   = iocon_q;
    gppu_d    = gppu_q;
    olat_d    = olat_q;
    wr_en     = 1'b0;
    rd_done   = 1'b0;
    case (state_q)
      ST_IDLE:   if (cs_fall) state_d = ST_OPCODE;
      ST_OPCODE: if (byte_done) begin
        if (rx_byte[7:4] == OPCODE_PREFIX &&
            (!iocon_q[IOCON_HAEN] || rx_byte[3:1] == HW_ADDR)) begin
          state_d = ST_ADDR;
          rw_d    = rx_byte[0];
        end else begin
          state_d = ST_IGNORE;
        end
      end
      ST_ADDR:   if (byte_done) begin
        ptr_d   = rx_byte;
        state_d = ST_DATA;
      end
      ST_DATA:   if (byte_done) begin
        wr_en   = ~rw_q;
        rd_done = rw_q;
        if (!iocon_q[IOCON_SEQOP]) ptr_d = (ptr_q == ADDR_LAST) ? 8'h00 : ptr_q + 8'd1;
      end
      default: ;
    endcase
    if (cs_s) state_d = ST_IDLE;

    // INTF and INTCAP are read-only; GPIO writes land in the output latch.
    if (wr_en) begin
      case (ptr_base)
        ADDR_IODIR:           iodir_d   = merge_byte(iodir_q, port_b, rx_byte);
        ADDR_GPINTEN:         gpinten_d = merge_byte(gpinten_q, port_b, rx_byte);
        ADDR_IOCON:           iocon_d   = rx_byte;
        ADDR_GPPU:            gppu_d    = merge_byte(gppu_q, port_b, rx_byte);
        ADDR_GPIO, ADDR_OLAT: olat_d    = merge_byte(olat_q, port_b, rx_byte);
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign chg[gi]    = gpinten_q[gi*8 +: 8] & iodir_q[gi*8 +: 8] &
                        (pins_s[gi*8 +: 8] ^ pins_prev_q[gi*8 +: 8]);
    assign rd_clr[gi] = rd_done && (port_b == gi[0]) &&
                        (ptr_base == ADDR_GPIO || ptr_base == ADDR_INTCAP);
  end

  // A fresh change beats a same-cycle clear, so an edge is never lost.
  always_comb begin
    intf_d      = intf_q;
    intcap_d    = intcap_q;
    pins_prev_d = pins_s;
    for (int p = 0; p < 2; p++) begin
      if (chg[p] != 8'h00 && (intf_q[p*8 +: 8] == 8'h00 || rd_clr[p])) begin
        intf_d[p*8 +: 8]   = chg[p];
        intcap_d[p*8 +: 8] = pins_s[p*8 +: 8];
      end else if (rd_clr[p]) begin
        intf_d[p*8 +: 8] = 8'h00;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rw_q        <= 1'b0;
      ptr_q       <= 8'h00;
      iodir_q     <= IODIR_RST;
      gpinten_q   <= REG16_RST;
      iocon_q     <= IOCON_RST;
      gppu_q      <= REG16_RST;
      intf_q      <= REG16_RST;
      intcap_q    <= REG16_RST;
      olat_q      <= REG16_RST;
      pins_prev_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      rw_q        <= rw_d;
      ptr_q       <= ptr_d;
      iodir_q     <= iodir_d;
      gpinten_q   <= gpinten_d;
      iocon_q     <= iocon_d;
      gppu_q      <= gppu_d;
      intf_q      <= intf_d;
      intcap_q    <= intcap_d;
      olat_q      <= olat_d;
      pins_prev_q <= pins_prev_d;
    end
  end

  assign int_active  = iocon_q[IOCON_MIRROR] ? (|intf_q) : (|intf_q[7:0]);
  assign inta        = iocon_q[IOCON_INTPOL] ? int_active : ~int_active;
  assign spi.miso_oe = (state_q == ST_DATA) & rw_q;
  assign spi.miso    = spi.miso_oe & miso_bit;
  assign gpio_out    = olat_q;
  assign iodir       = iodir_q;

endmodule

// File: tb/tb_mcp23s17_responder.sv
// Directed bench for mcp23s17_responder: expected read bytes go into a queue,
// and a bus monitor deserialises miso during the data phase and compares.
module tb_mcp23s17_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] gpio_in = 16'h0000;
  logic [15:0] gpio_out, iodir;
  logic        inta;

  mcp23s17_responder_if bus ();

  mcp23s17_responder #(.HW_ADDR(3'd3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .spi      (bus.slave),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .iodir    (iodir),
    .inta     (inta)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Monitor: samples miso at each host sck rise while the responder drives it.
  initial begin
    int         bits = 0;
    logic [7:0] sh   = 8'h00;
    forever begin
      @(posedge bus.sck or posedge bus.cs);
      if (bus.cs === 1'b1) begin
        bits = 0;
      end else if (bus.miso_oe === 1'b1) begin
        sh = {sh[6:0], bus.miso};
        bits++;
        if (bits == 8) begin
          bits = 0;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL miso_byte: got unexpected byte 0x%02h, required none", sh);
          end else begin
            check("miso_byte", {24'd0, sh}, {24'd0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      bus.mosi = b[i];
      wclk(5);
      bus.sck = 1'b1;
      wclk(5);
      bus.sck = 1'b0;
    end
  endtask

  task automatic cs_low();
    bus.cs = 1'b0;
    wclk(5);
  endtask

  task automatic cs_high();
    wclk(5);
    bus.cs = 1'b1;
    wclk(10);
  endtask

  task automatic xfer(input logic [7:0] op, input logic [7:0] addr, input int n,
                      input logic [7:0] d0 = 8'h00, input logic [7:0] d1 = 8'h00,
                      input logic [7:0] d2 = 8'h00);
    logic [7:0] d [3];
    d = '{d0, d1, d2};
    cs_low();
    spi_bits(op, 8);
    spi_bits(addr, 8);
    for (int i = 0; i < n; i++) spi_bits(d[i], 8);
    cs_high();
  endtask

  task automatic rd(input logic [7:0] op, input logic [7:0] addr, input int n,
                    input logic [7:0] e0 = 8'h00, input logic [7:0] e1 = 8'h00,
                    input logic [7:0] e2 = 8'h00);
    logic [7:0] e [3];
    e = '{e0, e1, e2};
    for (int i = 0; i < n; i++) exp_q.push_back(e[i]);
    xfer(op, addr, n);
  endtask

  initial begin
    int waited;
    bus.sck  = 1'b0;
    bus.cs   = 1'b1;
    bus.mosi = 1'b0;
    wclk(4);
    check("rst_iodir", iodir, 16'hFFFF);
    check("rst_gpio_out", gpio_out, 16'h0000);
    check("rst_inta", inta, 1'b1);
    check("rst_miso", bus.miso, 1'b0);
    check("rst_miso_oe", bus.miso_oe, 1'b0);
    rst_n = 1'b1;
    wclk(10);

    rd(8'h41, 8'h00, 1, 8'hFF);
    check("idle_miso_oe", bus.miso_oe, 1'b0);
    check("idle_inta", inta, 1'b1);

    xfer(8'h40, 8'h0C, 2, 8'hAA, 8'h55);
    rd(8'h41, 8'h0C, 2, 8'hAA, 8'h55);

    gpio_in = 16'hA53C;
    wclk(5);
    rd(8'h41, 8'h12, 2, 8'h3C, 8'hA5);

    xfer(8'h40, 8'h12, 1, 8'h5A);
    check("gpio_write_olat", gpio_out, 16'h005A);
    rd(8'h41, 8'h14, 2, 8'h5A, 8'h00);
    rd(8'h41, 8'h15, 2, 8'h00, 8'hFF);

    xfer(8'h40, 8'h02, 1, 8'h77);
    rd(8'h41, 8'h02, 1, 8'h00);

    xfer(8'h40, 8'h00, 1, 8'h0F);
    check("iodir_write", iodir, 16'hFF0F);
    rd(8'h41, 8'h12, 1, 8'h5C);
    xfer(8'h40, 8'h00, 1, 8'hFF);

    xfer(8'h40, 8'h0A, 1, 8'h20);
    rd(8'h41, 8'h0C, 2, 8'hAA, 8'hAA);
    xfer(8'h40, 8'h0A, 1, 8'h00);

    gpio_in = 16'hA5FF;
    wclk(5);
    xfer(8'h40, 8'h04, 1, 8'h01);
    check("int_idle_inta", inta, 1'b1);
    gpio_in = 16'hA5FE;
    waited = 0;
    while (inta !== 1'b0 && waited < 4) begin
      wclk(1);
      waited++;
    end
    check("int_inta_asserted", inta, 1'b0);
    gpio_in = 16'hA5FF;
    wclk(6);
    check("int_inta_held", inta, 1'b0);
    rd(8'h41, 8'h0E, 3, 8'h01, 8'h00, 8'hFE);
    check("int_inta_cleared", inta, 1'b1);
    xfer(8'h40, 8'h04, 1, 8'h00);

    xfer(8'h40, 8'h0A, 1, 8'h08);
    xfer(8'h40, 8'h0C, 1, 8'h11);
    cs_low();
    spi_bits(8'h41, 8);
    spi_bits(8'h0C, 8);
    spi_bits(8'h00, 8);
    check("haen_mismatch_miso_oe", bus.miso_oe, 1'b0);
    cs_high();
    rd(8'h47, 8'h0C, 1, 8'hAA);
    xfer(8'h46, 8'h0C, 1, 8'h33);
    rd(8'h47, 8'h0C, 1, 8'h33);

    cs_low();
    spi_bits(8'h46, 8);
    spi_bits(8'h14, 8);
    spi_bits(8'hFF, 5);
    cs_high();
    check("partial_byte_olat", gpio_out, 16'h005A);

    cs_low();
    spi_bits(8'h46, 8);
    spi_bits(8'h14, 8);
    spi_bits(8'hFF, 4);
    rst_n  = 1'b0;
    bus.cs = 1'b1;
    wclk(3);
    check("midrst_iodir", iodir, 16'hFFFF);
    check("midrst_gpio_out", gpio_out, 16'h0000);
    check("midrst_inta", inta, 1'b1);
    check("midrst_miso_oe", bus.miso_oe, 1'b0);
    rst_n = 1'b1;
    wclk(10);
    rd(8'h41, 8'h0C, 2, 8'h00, 8'h00);
    rd(8'h41, 8'h0A, 1, 8'h00);
    rd(8'h41, 8'h00, 2, 8'hFF, 8'hFF);

    wclk(5);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
